// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive-side blocks.
//   UART_DATA_W  width of one received byte
//   cap_state_t  capture FSM encoding used by uart_rx_fifo
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic {
    CAP_IDLE     = 1'b0,
    CAP_ACK_WAIT = 1'b1
  } cap_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x UART_DATA_W storage for the receive FIFO.
// The array itself has no reset, so a reset leaves stale bytes behind. Only
// the read-data register is reset.
// Ports:
//   CLK, RST     clock, asynchronous active-high reset (read register only)
//   we/waddr/wdata  synchronous write port
//   re/raddr     synchronous read request; rdata updates on the next edge
//   rdata        registered read data, holds its value when re=0
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [UART_DATA_W-1:0] wdata,
  input  logic                   re,
  input  logic [ADDR_W-1:0]      raddr,
  output logic [UART_DATA_W-1:0] rdata
);

  logic [UART_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // A write and a read to the same slot in one cycle return the old byte,
  // which is the head being read when the FIFO is full.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: takes bytes from the UART receiver (RX_READY/RX_DATA), acks
// each one with a single RX_READY_CLR pulse and buffers it for the host.
// A byte that arrives while the FIFO is full, with no read in the same
// cycle, is dropped. Dropping a byte sets the sticky OVERRUN flag.
// Optional feature macro: UART_RX_FIFO_WATERMARK_EN adds ALMOST_FULL
// (COUNT >= WATERMARK).
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   RX_READY/RX_DATA  receiver byte-available level and byte
//   RX_READY_CLR      registered one-cycle ack to the receiver
//   RD_EN             host read request; ignored while EMPTY
//   RD_DATA/RD_VALID  registered read byte and its one-cycle valid pulse
//   EMPTY/FULL/COUNT  registered occupancy, 0..DEPTH
//   OVERRUN/OVERRUN_CLR  sticky drop flag and its clear (set wins)
//   ALMOST_FULL       only with UART_RX_FIFO_WATERMARK_EN
//
// Capture FSM
//   state        | meaning
//   CAP_IDLE     | waiting for RX_READY; on it, write or drop and ack
//   CAP_ACK_WAIT | byte taken, waiting for the receiver to drop RX_READY
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH     = 16,
  parameter  int WATERMARK = 12,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_READY,
  input  logic [UART_DATA_W-1:0] RX_DATA,
  output logic                   RX_READY_CLR,
  input  logic                   RD_EN,
  output logic [UART_DATA_W-1:0] RD_DATA,
  output logic                   RD_VALID,
  output logic                   EMPTY,
  output logic                   FULL,
  output logic [ADDR_W:0]        COUNT,
  output logic                   OVERRUN,
  input  logic                   OVERRUN_CLR
`ifdef UART_RX_FIFO_WATERMARK_EN
  ,
  output logic                   ALMOST_FULL
`endif
);

  if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two in 2..256");
  end
  if (WATERMARK < 1 || WATERMARK > DEPTH) begin : g_bad_watermark
    $error("uart_rx_fifo: WATERMARK must be in 1..DEPTH");
  end

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  cap_state_t        cap_state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              cap_req;
  logic              rd_fire;
  logic              drop;
  logic              wr_fire;
  logic [ADDR_W:0]   count_next;

  assign cap_req = (cap_state == CAP_IDLE) && RX_READY;
  assign rd_fire = RD_EN && !EMPTY;
  // A read in the same cycle frees the slot, so full alone is not a drop.
  assign drop    = cap_req && FULL && !rd_fire;
  assign wr_fire = cap_req && !drop;

  always_comb begin
    count_next = COUNT;
    case ({wr_fire, rd_fire})
      2'b10:   count_next = COUNT + 1'b1;
      2'b01:   count_next = COUNT - 1'b1;
      default: count_next = COUNT;
    endcase
  end

  // ACK_WAIT makes sure the byte is taken only once. The receiver's READY
  // needs a cycle to fall after the ack, and it stays high if a new byte
  // lands together with the clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cap_state    <= CAP_IDLE;
      RX_READY_CLR <= 1'b0;
    end else begin
      case (cap_state)
        CAP_IDLE: begin
          RX_READY_CLR <= RX_READY;
          if (RX_READY) cap_state <= CAP_ACK_WAIT;
        end
        CAP_ACK_WAIT: begin
          RX_READY_CLR <= 1'b0;
          if (!RX_READY) cap_state <= CAP_IDLE;
        end
        default: begin
          RX_READY_CLR <= 1'b0;
          cap_state    <= CAP_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      COUNT    <= '0;
      EMPTY    <= 1'b1;
      FULL     <= 1'b0;
      RD_VALID <= 1'b0;
      OVERRUN  <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      COUNT    <= count_next;
      EMPTY    <= (count_next == '0);
      FULL     <= (count_next == DEPTH_CNT);
      RD_VALID <= rd_fire;
      if (drop)             OVERRUN <= 1'b1;
      else if (OVERRUN_CLR) OVERRUN <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_WATERMARK_EN
  localparam logic [ADDR_W:0] WM_CNT = (ADDR_W + 1)'(WATERMARK);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ALMOST_FULL <= 1'b0;
    else     ALMOST_FULL <= (count_next >= WM_CNT);
  end
`endif

  uart_fifo_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .RST   (RST),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (RX_DATA),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (RD_DATA)
  );

endmodule
